// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: save/restore LIFO for the MCU C and Z flags.
// PUSH captures {C_IN,Z_IN} on interrupt entry; POP returns the top entry on
// C_OUT/Z_OUT together with a one-cycle FLG_LD strobe into the flag registers.
// Optional feature macro: FLAG_CLR_ON_PUSH_EN (pulse FLG_CLR after each accepted push).
//
// Strobe semantics: PUSH and POP are single-cycle requests with no backpressure.
// A request that cannot be honoured (push when full, pop when empty) is dropped
// and recorded in the sticky OVF/UNF flags; FULL/EMPTY tell the control unit in
// advance whether the next request will be accepted.
module flag_shadow_stack #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          C_IN,
    input  logic          Z_IN,
    input  logic          PUSH,
    input  logic          POP,
    input  logic          CLR_ERR,
    output logic          C_OUT,
    output logic          Z_OUT,
    output logic          FLG_LD,
    output logic          FLG_CLR,
    output logic [CW-1:0] COUNT,
    output logic          FULL,
    output logic          EMPTY,
    output logic          OVF,
    output logic          UNF
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } fsm_state_e;

    // state_q is the FSM state; it is kept as a plainly named register so
    // checkers can bind to it directly.
    fsm_state_e state_q;
    fsm_state_e state_d;

    logic [1:0]    mem [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] top_idx;
    logic [1:0]    top_val;
    logic          c_q;
    logic          z_q;
    logic          ovf_q;
    logic          unf_q;

    logic full;
    logic empty;
    logic pop_acc;   // pop that returns an entry (plain pop or swap)
    logic swap;      // push and pop together on a non-empty stack
    logic push_acc;  // push that grows the stack
    logic ovf_set;
    logic unf_set;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = count_q - CW'(1);

    assign pop_acc  = POP && !empty;
    assign swap     = PUSH && POP && !empty;
    // An empty-stack pop does not block a concurrent push.
    assign push_acc = PUSH && !full && !(POP && !empty);
    assign ovf_set  = PUSH && !POP && full;
    assign unf_set  = POP && empty;

    // Read the current top-of-stack entry.
    always_comb begin
        top_val = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == CW'(i)) begin
                top_val = mem[i];
            end
        end
    end

    // Stack storage: no reset, entries at or above COUNT are don't-care.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_acc && count_q == CW'(i)) begin
                    mem[i] <= {C_IN, Z_IN};
                end else if (swap && top_idx == CW'(i)) begin
                    mem[i] <= {C_IN, Z_IN};
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stay in RESTORE exactly as long as pops keep arriving.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:    state_d = pop_acc ? ST_RESTORE : ST_IDLE;
            ST_RESTORE: state_d = pop_acc ? ST_RESTORE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Occupancy count, restored flag values and sticky error flags.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (push_acc) begin
                count_q <= count_q + CW'(1);
            end else if (pop_acc && !swap) begin
                count_q <= count_q - CW'(1);
            end

            if (pop_acc) begin
                c_q <= top_val[1];
                z_q <= top_val[0];
            end

            // A new error in the same cycle as CLR_ERR wins.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (CLR_ERR) begin
                ovf_q <= 1'b0;
            end

            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (CLR_ERR) begin
                unf_q <= 1'b0;
            end
        end
    end

`ifdef FLAG_CLR_ON_PUSH_EN
    logic clr_q;

    // One-cycle clear pulse after every accepted push, including a swap.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= push_acc || swap;
        end
    end

    assign FLG_CLR = clr_q;
`else
    assign FLG_CLR = 1'b0;
`endif

    assign FLG_LD = (state_q == ST_RESTORE);
    assign C_OUT  = c_q;
    assign Z_OUT  = z_q;
    assign COUNT  = count_q;
    assign FULL   = full;
    assign EMPTY  = empty;
    assign OVF    = ovf_q;
    assign UNF    = unf_q;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Bench for flag_shadow_stack: a reference model computes the post-edge
// outputs when each cycle's stimulus is driven and pushes them onto exp_q;
// the monitor pops and compares 1 time unit after every rising edge.
// Honours FLAG_CLR_ON_PUSH_EN the same way as the design.
module tb_flag_shadow_stack;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int W     = 13;

`ifdef FLAG_CLR_ON_PUSH_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          CLK;
    logic          RST_N;
    logic          C_IN;
    logic          Z_IN;
    logic          PUSH;
    logic          POP;
    logic          CLR_ERR;
    logic          C_OUT;
    logic          Z_OUT;
    logic          FLG_LD;
    logic          FLG_CLR;
    logic [CW-1:0] COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          OVF;
    logic          UNF;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    flag_shadow_stack #(.DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .C_IN    (C_IN),
        .Z_IN    (Z_IN),
        .PUSH    (PUSH),
        .POP     (POP),
        .CLR_ERR (CLR_ERR),
        .C_OUT   (C_OUT),
        .Z_OUT   (Z_OUT),
        .FLG_LD  (FLG_LD),
        .FLG_CLR (FLG_CLR),
        .COUNT   (COUNT),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .OVF     (OVF),
        .UNF     (UNF)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h (C Z LD CLR CNT[5] FULL EMPTY OVF UNF)", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic c, z, ld, clr, input int cnt,
                                          input logic full, empty, ovf, unf);
        return {c, z, ld, clr, 5'(cnt), full, empty, ovf, unf};
    endfunction

    logic [W-1:0] mon_exp;
    string        mon_tag;

    // Monitor: compare the DUT against the oldest expected entry.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            check(mon_tag,
                  {19'b0, pack(C_OUT, Z_OUT, FLG_LD, FLG_CLR, int'(COUNT), FULL, EMPTY, OVF, UNF)},
                  {19'b0, mon_exp});
        end
    end

    // ---------------- reference model ----------------
    logic [1:0] m_mem [DEPTH];
    int   m_cnt = 0;
    logic m_c = 0, m_z = 0, m_ld = 0, m_clr = 0, m_ovf = 0, m_unf = 0;

    task automatic model_step(input bit rst_n, push, pop, c, z, clr_err);
        bit ovf_s, unf_s;
        ovf_s = 0;
        unf_s = 0;
        if (!rst_n) begin
            m_cnt = 0; m_c = 0; m_z = 0; m_ld = 0; m_clr = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        m_ld  = 0;
        m_clr = 0;
        if (pop && m_cnt > 0) begin
            {m_c, m_z} = m_mem[m_cnt-1];
            m_ld = 1;
            if (push) begin
                m_mem[m_cnt-1] = {c, z};
                m_clr = CLR_EN;
            end else begin
                m_cnt--;
            end
        end else begin
            if (pop) unf_s = 1;
            if (push) begin
                if (m_cnt == DEPTH) begin
                    ovf_s = 1;
                end else begin
                    m_mem[m_cnt] = {c, z};
                    m_cnt++;
                    m_clr = CLR_EN;
                end
            end
        end
        if (ovf_s) m_ovf = 1; else if (clr_err) m_ovf = 0;
        if (unf_s) m_unf = 1; else if (clr_err) m_unf = 0;
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input string tag, input bit rst_n, push, pop, c, z, clr_err);
        @(negedge CLK);
        RST_N   = rst_n;
        PUSH    = push;
        POP     = pop;
        C_IN    = c;
        Z_IN    = z;
        CLR_ERR = clr_err;
        model_step(rst_n, push, pop, c, z, clr_err);
        exp_q.push_back(pack(m_c, m_z, m_ld, m_clr, m_cnt,
                             m_cnt == DEPTH, m_cnt == 0, m_ovf, m_unf));
        tag_q.push_back(tag);
    endtask

    task automatic do_push(input string tag, input bit c, z);
        cyc(tag, 1, 1, 0, c, z, 0);
    endtask

    task automatic do_pop(input string tag);
        cyc(tag, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic do_idle(input string tag);
        cyc(tag, 1, 0, 0, 0, 0, 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        RST_N = 0; PUSH = 0; POP = 0; C_IN = 0; Z_IN = 0; CLR_ERR = 0;

        // Reset, with a push/pop presented that must be ignored.
        cyc("reset0", 0, 1, 1, 1, 1, 0);
        cyc("reset1", 0, 0, 0, 0, 0, 0);

        // Single push / pop round trip.
        do_push("push_10", 1, 0);
        do_pop("pop_10");
        do_idle("idle_after_pop");

        // Fill to DEPTH, overflow, drain with back-to-back pops.
        do_push("fill0", 1, 1);
        do_push("fill1", 0, 1);
        do_push("fill2", 1, 0);
        do_push("fill3", 0, 0);
        do_push("ovf_push", 1, 1);
        do_pop("drain0");
        do_pop("drain1");
        do_pop("drain2");
        do_pop("drain3");
        do_idle("drain_idle");

        // Underflow and error clearing.
        cyc("clr_ovf", 1, 0, 0, 0, 0, 1);
        do_pop("unf_pop");
        cyc("clr_unf", 1, 0, 0, 0, 0, 1);
        cyc("clr_vs_unf", 1, 0, 1, 0, 0, 1);
        cyc("clr_unf2", 1, 0, 0, 0, 0, 1);

        // Push and pop together on an empty stack: underflow plus push.
        cyc("empty_swap", 1, 1, 1, 1, 1, 0);
        do_pop("empty_swap_pop");
        cyc("clr_unf3", 1, 0, 0, 0, 0, 1);

        // Swap at COUNT=2 with top {1,0}.
        do_push("swap_pre0", 0, 1);
        do_push("swap_pre1", 1, 0);
        cyc("swap", 1, 1, 1, 0, 1, 0);
        do_pop("after_swap");
        do_pop("after_swap2");
        do_idle("swap_idle");

        // Swap while full leaves COUNT at DEPTH.
        do_push("full_a", 1, 1);
        do_push("full_b", 0, 0);
        do_push("full_c", 1, 0);
        do_push("full_d", 0, 1);
        cyc("full_swap", 1, 1, 1, 1, 1, 0);
        do_pop("full_swap_pop");

        // Reset during a RESTORE cycle at COUNT=3.
        cyc("rst_pre", 0, 0, 0, 0, 0, 0);
        do_push("rst_p0", 1, 1);
        do_push("rst_p1", 1, 0);
        do_push("rst_p2", 0, 1);
        do_pop("rst_pop");
        cyc("rst_mid_restore", 0, 0, 0, 0, 0, 0);
        do_idle("rst_after");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(0, 99) != 0,
                $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 40,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0);
        end

        do_idle("final_idle");
        repeat (2) @(negedge CLK);
        check("drain_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
